control_unit_multicycle: RTL and testbench

//  Multicycle RV32I control unit (lw, sw, R-type, I-type ALU, beq/bne, jal). Successor to the single-cycle

---
 rtl/control_unit_multicycle.sv | 214 +++++++++++++++++++++
 tb/tb_control_unit_multicycle.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_multicycle.sv
// control_unit_multicycle
//   Multicycle RV32I control unit covering lw, sw, R-type, I-type ALU, beq/bne and jal.
//   A Moore FSM steps one shared memory and ALU through 3-5 cycles per instruction.
//   Ports:
//     clk, reset         clock (rising edge), asynchronous active-high reset
//     op, funct3, funct7 instruction fields IR[6:0], IR[14:12], IR[30]
//     Zero, MemReady     ALU zero flag, memory access completes this cycle
//     PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB
//                        datapath controls
//     ALUControl, ImmSrc ALU operation and immediate format
//     IllegalOp          one-cycle pulse in DECODE for an unsupported opcode
//     State              current state encoding (debug)
module control_unit_multicycle #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit BRANCH_EXT    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRead = 4'd3,
        StMemWb   = 4'd4,
        StMemWrite= 4'd5,
        StExecR   = 4'd6,
        StExecI   = 4'd7,
        StAluWb   = 4'd8,
        StBranch  = 4'd9,
        StJal     = 4'd10
    } state_e;

    localparam logic [6:0] OpLw    = 7'b0000011;
    localparam logic [6:0] OpSw    = 7'b0100011;
    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpIType = 7'b0010011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;

    state_e     state_q, state_d;
    logic       mem_ready;
    logic       pc_update;
    logic       branch;
    logic       taken;
    logic [1:0] alu_op;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;
    logic       illegal_raw;

    // Without the handshake the memory is assumed to always complete in one cycle.
    assign mem_ready = MEM_HANDSHAKE ? MemReady : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore outputs.
    always_comb begin
        state_d       = StFetch;
        pc_update     = 1'b0;
        branch        = 1'b0;
        alu_op        = 2'b00;
        AdrSrc        = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        case (state_q)
            StFetch: begin
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                ir_write_raw = mem_ready;
                pc_update    = mem_ready;
                state_d      = mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
                // Precompute OldPC + imm into ALUOut for branches.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRType:    state_d = StExecR;
                    OpIType:    state_d = StExecI;
                    OpBr:       state_d = StBranch;
                    OpJal:      state_d = StJal;
                    default: begin
                        state_d     = StFetch;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                AdrSrc  = 1'b1;
                state_d = mem_ready ? StMemWb : StMemRead;
            end
            StMemWb: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
                state_d       = StFetch;
            end
            StMemWrite: begin
                // Strobe held through stalls; the memory commits when it signals ready.
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                state_d       = mem_ready ? StFetch : StMemWrite;
            end
            StExecR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b00;
                alu_op  = 2'b10;
                state_d = StAluWb;
            end
            StExecI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_d = StAluWb;
            end
            StAluWb: begin
                reg_write_raw = 1'b1;
                state_d       = StFetch;
            end
            StBranch: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b00;
                alu_op  = 2'b01;
                branch  = 1'b1;
                state_d = StFetch;
            end
            StJal: begin
                // PC takes the target held in ALUOut while ALU forms OldPC + 4 for the link.
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = StAluWb;
            end
            default: state_d = StFetch;
        endcase
    end

    assign taken = (BRANCH_EXT && (funct3 == 3'b001)) ? !Zero : Zero;

    // Write enables are suppressed for the whole reset pulse so an aborted
    // instruction leaves no partial update behind.
    assign PCWrite   = !reset && (pc_update || (branch && taken));
    assign IRWrite   = !reset && ir_write_raw;
    assign MemWrite  = !reset && mem_write_raw;
    assign RegWrite  = !reset && reg_write_raw;
    assign IllegalOp = !reset && illegal_raw;
    assign State     = state_q;

    // ALU decoder.
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] && funct7) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format depends on the opcode alone.
    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            OpSw:    ImmSrc = 3'b001;
            OpBr:    ImmSrc = 3'b010;
            OpJal:   ImmSrc = 3'b011;
            default: ImmSrc = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_control_unit_multicycle.sv
module tb_control_unit_multicycle;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;
    logic [3:0] State;

    control_unit_multicycle #(
        .MEM_HANDSHAKE(1'b1),
        .BRANCH_EXT   (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct3    (funct3),
        .funct7    (funct7),
        .Zero      (Zero),
        .MemReady  (MemReady),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUControl(ALUControl),
        .ImmSrc    (ImmSrc),
        .IllegalOp (IllegalOp),
        .State     (State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, mw, rw, adr;
        logic [1:0] rs, a, b;
        logic [2:0] alu, imm;
        logic       ill;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic exp_t mk(int st, int pcw, int irw, int mw, int rw, int adr,
                                int rs, int a, int b, int alu, int imm, int ill);
        exp_t e;
        e.st  = 4'(st);
        e.pcw = 1'(pcw);
        e.irw = 1'(irw);
        e.mw  = 1'(mw);
        e.rw  = 1'(rw);
        e.adr = 1'(adr);
        e.rs  = 2'(rs);
        e.a   = 2'(a);
        e.b   = 2'(b);
        e.alu = 3'(alu);
        e.imm = 3'(imm);
        e.ill = 1'(ill);
        return e;
    endfunction

    function automatic exp_t fetch_e(int imm);
        return mk(0, 1, 1, 0, 0, 0, 2, 0, 2, 0, imm, 0);
    endfunction

    function automatic exp_t decode_e(int imm);
        return mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, imm, 0);
    endfunction

    function automatic exp_t aluwb_e(int imm);
        return mk(8, 0, 0, 0, 1, 0, 0, 0, 0, 0, imm, 0);
    endfunction

    task automatic chk(input string tag, input string fld, input logic [3:0] obs,
                       input logic [3:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s.%s observed %0h expected %0h", tag, fld, obs, exp);
        end
    endtask

    // Expected outputs are queued when the step is driven and popped once outputs settle.
    task automatic check_now(input string tag, input exp_t e);
        exp_t g;
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        chk(tag, "State",      State,             g.st);
        chk(tag, "PCWrite",    4'(PCWrite),       4'(g.pcw));
        chk(tag, "IRWrite",    4'(IRWrite),       4'(g.irw));
        chk(tag, "MemWrite",   4'(MemWrite),      4'(g.mw));
        chk(tag, "RegWrite",   4'(RegWrite),      4'(g.rw));
        chk(tag, "AdrSrc",     4'(AdrSrc),        4'(g.adr));
        chk(tag, "ResultSrc",  4'(ResultSrc),     4'(g.rs));
        chk(tag, "ALUSrcA",    4'(ALUSrcA),       4'(g.a));
        chk(tag, "ALUSrcB",    4'(ALUSrcB),       4'(g.b));
        chk(tag, "ALUControl", 4'(ALUControl),    4'(g.alu));
        chk(tag, "ImmSrc",     4'(ImmSrc),        4'(g.imm));
        chk(tag, "IllegalOp",  4'(IllegalOp),     4'(g.ill));
    endtask

    task automatic cyc(input string tag, input exp_t e);
        check_now(tag, e);
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        op       = 7'b0000000;
        funct3   = 3'b000;
        funct7   = 1'b0;
        Zero     = 1'b0;
        MemReady = 1'b1;
        @(negedge clk);
        // Reset: FETCH values, write enables held low even with MemReady=1.
        check_now("reset", mk(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0));
        @(negedge clk);

        // lw, no stalls: 0,1,2,3,4 then FETCH
        op    = 7'b0000011;
        reset = 1'b0;
        cyc("lw.fetch",   fetch_e(0));
        cyc("lw.decode",  decode_e(0));
        cyc("lw.memadr",  mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        cyc("lw.memread", mk(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        cyc("lw.memwb",   mk(4, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));

        // sw with one fetch stall and two write stalls
        op       = 7'b0100011;
        MemReady = 1'b0;
        cyc("sw.fetch_stall", mk(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 0));
        MemReady = 1'b1;
        cyc("sw.fetch",   fetch_e(1));
        cyc("sw.decode",  decode_e(1));
        cyc("sw.memadr",  mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
        MemReady = 1'b0;
        cyc("sw.memwr0",  mk(5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0));
        cyc("sw.memwr1",  mk(5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0));
        MemReady = 1'b1;
        cyc("sw.memwr2",  mk(5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0));

        // R-type sub, aborted by reset in EXECR, then rerun to completion
        op     = 7'b0110011;
        funct3 = 3'b000;
        funct7 = 1'b1;
        cyc("sub.fetch",  fetch_e(0));
        cyc("sub.decode", decode_e(0));
        check_now("sub.execr", mk(6, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0));
        #2;
        reset = 1'b1;
        check_now("rst.async", mk(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0));
        @(negedge clk);
        check_now("rst.held",  mk(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0));
        reset = 1'b0;
        check_now("rst.release", fetch_e(0));
        @(negedge clk);
        cyc("sub.decode2", decode_e(0));
        cyc("sub.execr2",  mk(6, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0));
        cyc("sub.aluwb",   aluwb_e(0));

        // addi with funct7=1 stays an add
        op = 7'b0010011;
        cyc("addi.fetch",  fetch_e(0));
        cyc("addi.decode", decode_e(0));
        cyc("addi.execi",  mk(7, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        cyc("addi.aluwb",  aluwb_e(0));

        // slti -> slt
        funct3 = 3'b010;
        funct7 = 1'b0;
        cyc("slti.fetch",  fetch_e(0));
        cyc("slti.decode", decode_e(0));
        cyc("slti.execi",  mk(7, 0, 0, 0, 0, 0, 0, 2, 1, 5, 0, 0));
        cyc("slti.aluwb",  aluwb_e(0));

        // R-type or
        op     = 7'b0110011;
        funct3 = 3'b110;
        cyc("or.fetch",  fetch_e(0));
        cyc("or.decode", decode_e(0));
        cyc("or.execr",  mk(6, 0, 0, 0, 0, 0, 0, 2, 0, 3, 0, 0));
        cyc("or.aluwb",  aluwb_e(0));

        // beq taken
        op     = 7'b1100011;
        funct3 = 3'b000;
        Zero   = 1'b1;
        cyc("beq.fetch",  fetch_e(2));
        cyc("beq.decode", decode_e(2));
        cyc("beq.branch", mk(9, 1, 0, 0, 0, 0, 0, 2, 0, 1, 2, 0));

        // bne with Zero=1: not taken
        funct3 = 3'b001;
        cyc("bne0.fetch",  fetch_e(2));
        cyc("bne0.decode", decode_e(2));
        cyc("bne0.branch", mk(9, 0, 0, 0, 0, 0, 0, 2, 0, 1, 2, 0));

        // bne with Zero=0: taken
        Zero = 1'b0;
        cyc("bne1.fetch",  fetch_e(2));
        cyc("bne1.decode", decode_e(2));
        cyc("bne1.branch", mk(9, 1, 0, 0, 0, 0, 0, 2, 0, 1, 2, 0));

        // jal
        op     = 7'b1101111;
        funct3 = 3'b000;
        cyc("jal.fetch",  fetch_e(3));
        cyc("jal.decode", decode_e(3));
        cyc("jal.jal",    mk(10, 1, 0, 0, 0, 0, 0, 1, 2, 0, 3, 0));
        cyc("jal.aluwb",  aluwb_e(3));

        // illegal opcode
        op = 7'b1111111;
        cyc("ill.fetch",  fetch_e(0));
        cyc("ill.decode", mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        cyc("ill.next",   fetch_e(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
